// File: rtl/add_sub_pipe.sv
// Two-stage pipelined signed adder/subtractor with overflow flag, optional
// saturation and an internal accumulator, under valid/ready flow control.
module add_sub_pipe #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             SUB,
   input  logic             ACC,
   input  logic             SAT,
   input  logic             CLR,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH:0]   ANS,
   output logic             CY_BR_OUT,
   output logic [WIDTH-1:0] ACC_Q
);

   localparam int unsigned SW = WIDTH + 1;
   localparam logic [SW-1:0] SMIN = {2'b11, {(WIDTH-1){1'b0}}};
   localparam logic [SW-1:0] SMAX = {2'b00, {(WIDTH-1){1'b1}}};

   // stage 1 operand registers
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic             s1_sub_q, s1_sub_d;
   logic             s1_acc_q, s1_acc_d;
   logic             s1_sat_q, s1_sat_d;

   // stage 2 result registers and accumulator
   logic             s2_valid_q, s2_valid_d;
   logic [SW-1:0]    ans_q, ans_d;
   logic             cy_q, cy_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             in_ready_c;
   logic             accept_c;
   logic             load_c;
   logic [WIDTH-1:0] left_c;
   logic [SW-1:0]    left_x_c;
   logic [SW-1:0]    b_x_c;
   logic [SW-1:0]    full_c;
   logic             ovf_c;
   logic [SW-1:0]    ans_c;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_sub_q   <= 1'b0;
         s1_acc_q   <= 1'b0;
         s1_sat_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         ans_q      <= '0;
         cy_q       <= 1'b0;
         acc_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_sub_q   <= s1_sub_d;
         s1_acc_q   <= s1_acc_d;
         s1_sat_q   <= s1_sat_d;
         s2_valid_q <= s2_valid_d;
         ans_q      <= ans_d;
         cy_q       <= cy_d;
         acc_q      <= acc_d;
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_sub_d   = s1_sub_q;
      s1_acc_d   = s1_acc_q;
      s1_sat_d   = s1_sat_q;
      s2_valid_d = s2_valid_q;
      ans_d      = ans_q;
      cy_d       = cy_q;
      acc_d      = acc_q;

      in_ready_c = !s1_valid_q || !s2_valid_q || OUT_READY;
      accept_c   = IN_VALID && in_ready_c;
      load_c     = s1_valid_q && (!s2_valid_q || OUT_READY);

      // exact sum in WIDTH+1 bits; overflow when the top two bits disagree
      left_c   = s1_acc_q ? acc_q : s1_a_q;
      left_x_c = {left_c[WIDTH-1], left_c};
      b_x_c    = {s1_b_q[WIDTH-1], s1_b_q};
      full_c   = s1_sub_q ? (left_x_c - b_x_c) : (left_x_c + b_x_c);
      ovf_c    = full_c[WIDTH] ^ full_c[WIDTH-1];
      if (s1_sat_q && ovf_c) begin
         ans_c = full_c[WIDTH] ? SMIN : SMAX;
      end else begin
         ans_c = full_c;
      end

      if (accept_c) begin
         s1_valid_d = 1'b1;
         s1_a_d     = A;
         s1_b_d     = B;
         s1_sub_d   = SUB;
         s1_acc_d   = ACC;
         s1_sat_d   = SAT;
      end else if (load_c) begin
         s1_valid_d = 1'b0;
      end

      if (load_c) begin
         s2_valid_d = 1'b1;
         ans_d      = ans_c;
         cy_d       = ovf_c;
         acc_d      = ans_c[WIDTH-1:0];
      end else if (OUT_READY) begin
         s2_valid_d = 1'b0;
      end

      // clear wins over a same-edge accumulator update
      if (CLR) begin
         acc_d = '0;
      end
   end

   assign IN_READY  = in_ready_c;
   assign OUT_VALID = s2_valid_q;
   assign ANS       = ans_q;
   assign CY_BR_OUT = cy_q;
   assign ACC_Q     = acc_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: WIDTH=4 and WIDTH=8 instances checked every cycle
// against an integer-arithmetic model, plus hand-computed directed results.
module tb_add_sub_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid[2], in_ready[2], sub[2], acc[2], sat[2], clr[2];
   logic out_valid[2], out_ready[2], cy[2];
   int   a_drv[2], b_drv[2];
   int   dut_ans[2], dut_acc[2];

   logic [3:0] a4, b4, acc4;
   logic [4:0] ans4;
   logic [7:0] a8, b8, acc8;
   logic [8:0] ans8;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   int cap_ans[$];
   bit cap_cy[$];

   // model state: pending operand beat, output slot, accumulator
   bit pend_v[2], psub[2], pacc[2], psat[2], out_v[2], cy_m[2];
   int pa[2], pb[2], ans_m[2], acc_m[2];

   assign a4 = a_drv[0][3:0];
   assign b4 = b_drv[0][3:0];
   assign a8 = a_drv[1][7:0];
   assign b8 = b_drv[1][7:0];
   assign dut_ans[0] = int'($signed(ans4));
   assign dut_ans[1] = int'($signed(ans8));
   assign dut_acc[0] = int'($signed(acc4));
   assign dut_acc[1] = int'($signed(acc8));

   add_sub_pipe #(.WIDTH(4)) u4 (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
      .A(a4), .B(b4), .SUB(sub[0]), .ACC(acc[0]), .SAT(sat[0]), .CLR(clr[0]),
      .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .ANS(ans4),
      .CY_BR_OUT(cy[0]), .ACC_Q(acc4)
   );

   add_sub_pipe #(.WIDTH(8)) u8 (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
      .A(a8), .B(b8), .SUB(sub[1]), .ACC(acc[1]), .SAT(sat[1]), .CLR(clr[1]),
      .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .ANS(ans8),
      .CY_BR_OUT(cy[1]), .ACC_Q(acc8)
   );

   always #5 clk = ~clk;

   function automatic int wd(int i);
      return (i == 0) ? 4 : 8;
   endfunction

   function automatic int wrapw(int v, int w);
      int m, h, r;
      m = 1 << w;
      h = 1 << (w - 1);
      r = (v + h) % m;
      if (r < 0) r = r + m;
      return r - h;
   endfunction

   function automatic bit rdy_m(int i);
      return !pend_v[i] || !out_v[i] || (out_ready[i] == 1'b1);
   endfunction

   function automatic bit load_m(int i);
      return pend_v[i] && (!out_v[i] || (out_ready[i] == 1'b1));
   endfunction

   function automatic int full_m(int i);
      int l;
      l = pacc[i] ? acc_m[i] : pa[i];
      return psub[i] ? (l - pb[i]) : (l + pb[i]);
   endfunction

   function automatic bit ovf_m(int i);
      int f, h;
      f = full_m(i);
      h = 1 << (wd(i) - 1);
      return (f > h - 1) || (f < -h);
   endfunction

   function automatic int ans_mf(int i);
      int f, h;
      f = full_m(i);
      h = 1 << (wd(i) - 1);
      if (!psat[i]) return f;
      if (f > h - 1) return h - 1;
      if (f < -h) return -h;
      return f;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            pend_v[i] <= 1'b0;
            out_v[i]  <= 1'b0;
            ans_m[i]  <= 0;
            cy_m[i]   <= 1'b0;
            acc_m[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (load_m(i)) begin
               ans_m[i] <= ans_mf(i);
               cy_m[i]  <= ovf_m(i);
            end
            if (clr[i] == 1'b1) acc_m[i] <= 0;
            else if (load_m(i)) acc_m[i] <= wrapw(ans_mf(i), wd(i));
            if (load_m(i)) out_v[i] <= 1'b1;
            else if (out_ready[i] == 1'b1) out_v[i] <= 1'b0;
            if ((in_valid[i] == 1'b1) && rdy_m(i)) begin
               pend_v[i] <= 1'b1;
               pa[i]     <= a_drv[i];
               pb[i]     <= b_drv[i];
               psub[i]   <= sub[i];
               pacc[i]   <= acc[i];
               psat[i]   <= sat[i];
            end else if (load_m(i)) begin
               pend_v[i] <= 1'b0;
            end
         end
      end
   end

   task automatic chk(string nm, int i, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s[u%0d]: got %0d, expected %0d at %0t", nm, wd(i), act, exp, $time);
      end
   endtask

   // continuous comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk("in_ready", i, int'(in_ready[i]), int'(rdy_m(i)));
            chk("out_valid", i, int'(out_valid[i]), int'(out_v[i]));
            chk("ans", i, dut_ans[i], ans_m[i]);
            chk("cy_br_out", i, int'(cy[i]), int'(cy_m[i]));
            chk("acc_q", i, dut_acc[i], acc_m[i]);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid[0] && out_ready[0]) begin
         cap_ans.push_back(dut_ans[0]);
         cap_cy.push_back(cy[0]);
      end
   end

   task automatic cycles(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat(int i, int a, int b, bit s, bit ac, bit st);
      int n;
      bit ok;
      n = 0;
      in_valid[i] = 1'b1;
      a_drv[i] = a;
      b_drv[i] = b;
      sub[i] = s;
      acc[i] = ac;
      sat[i] = st;
      do begin
         @(negedge clk);
         ok = (in_ready[i] == 1'b1);
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 50);
      chk("accept", i, int'(ok), 1);
   endtask

   task automatic idle(int i);
      in_valid[i] = 1'b0;
   endtask

   task automatic pop_chk(string nm, int ans_e, int cy_e);
      int a;
      bit c;
      chk({nm, "_present"}, 0, int'(cap_ans.size() > 0), 1);
      if (cap_ans.size() > 0) begin
         a = cap_ans.pop_front();
         c = cap_cy.pop_front();
         chk({nm, "_ans"}, 0, a, ans_e);
         chk({nm, "_cy"}, 0, int'(c), cy_e);
      end
   endtask

   task automatic clr_pulse();
      clr[0] = 1'b1;
      cycles(1);
      clr[0] = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b0; sub[i] = 1'b0; acc[i] = 1'b0; sat[i] = 1'b0;
         clr[i] = 1'b0; out_ready[i] = 1'b1; a_drv[i] = 0; b_drv[i] = 0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 0, int'(in_ready[0]), 1);
      chk("rst_out_valid", 0, int'(out_valid[0]), 0);
      chk("rst_ans", 0, dut_ans[0], 0);
      chk("rst_acc", 0, dut_acc[0], 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // basic add and saturated subtract
      beat(0, 7, 1, 0, 0, 0);
      beat(0, 3, -2, 0, 0, 0);
      beat(0, -8, 1, 1, 0, 1);
      beat(0, 7, -8, 1, 0, 1);
      idle(0);
      cycles(4);
      pop_chk("add_7p1", 8, 1);
      pop_chk("add_3m2", 1, 0);
      pop_chk("satsub_m8m1", -8, 1);
      pop_chk("satsub_7mm8", 7, 1);

      // accumulate chain, wrapping then saturating
      clr_pulse();
      for (int k = 0; k < 3; k++) beat(0, 0, 3, 0, 1, 0);
      idle(0);
      cycles(4);
      pop_chk("acc_1", 3, 0);
      pop_chk("acc_2", 6, 0);
      pop_chk("acc_3", 9, 1);
      chk("acc_wrap_q", 0, dut_acc[0], -7);
      clr_pulse();
      for (int k = 0; k < 3; k++) beat(0, 0, 3, 0, 1, 1);
      idle(0);
      cycles(4);
      pop_chk("accs_1", 3, 0);
      pop_chk("accs_2", 6, 0);
      pop_chk("accs_3", 7, 1);
      chk("acc_sat_q", 0, dut_acc[0], 7);

      // clear on the same edge as the third beat's stage-2 load
      clr_pulse();
      for (int k = 0; k < 3; k++) beat(0, 0, 3, 0, 1, 0);
      idle(0);
      clr[0] = 1'b1;
      cycles(1);
      clr[0] = 1'b0;
      @(negedge clk);
      chk("clr_coincident_acc", 0, dut_acc[0], 0);
      cycles(3);
      pop_chk("accc_1", 3, 0);
      pop_chk("accc_2", 6, 0);
      pop_chk("accc_3", 9, 1);

      // backpressure: two beats fill the pipe, then drain in order
      out_ready[0] = 1'b0;
      fork
         begin
            for (int k = 1; k <= 4; k++) beat(0, k, 0, 0, 0, 0);
            idle(0);
         end
      join_none
      cycles(6);
      @(negedge clk);
      chk("bp_in_ready", 0, int'(in_ready[0]), 0);
      chk("bp_out_valid", 0, int'(out_valid[0]), 1);
      chk("bp_ans_hold", 0, dut_ans[0], 1);
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      #1;
      chk("bp_ready_same_cycle", 0, int'(in_ready[0]), 1);
      wait fork;
      cycles(4);
      for (int k = 1; k <= 4; k++) pop_chk("bp_order", k, 0);
      chk("bp_no_extra", 0, cap_ans.size(), 0);

      // reset with both stages full
      out_ready[0] = 1'b0;
      beat(0, 1, 1, 0, 0, 0);
      beat(0, 2, 2, 0, 0, 0);
      idle(0);
      rst = 1'b1;
      #1;
      chk("mrst_out_valid", 0, int'(out_valid[0]), 0);
      chk("mrst_ans", 0, dut_ans[0], 0);
      chk("mrst_cy", 0, int'(cy[0]), 0);
      chk("mrst_acc", 0, dut_acc[0], 0);
      chk("mrst_in_ready", 0, int'(in_ready[0]), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready[0] = 1'b1;
      beat(0, 2, 3, 0, 0, 0);
      idle(0);
      cycles(4);
      pop_chk("mrst_first", 5, 0);
      chk("mrst_no_ghost", 0, cap_ans.size(), 0);

      // full-rate sweeps: exhaustive at WIDTH=4, all A/B at WIDTH=8
      fork
         begin
            for (int st = 0; st < 2; st++)
               for (int s = 0; s < 2; s++)
                  for (int a = -8; a < 8; a++)
                     for (int b = -8; b < 8; b++)
                        beat(0, a, b, 1'(s), 1'b0, 1'(st));
            idle(0);
         end
         begin
            for (int a = -128; a < 128; a++)
               for (int b = -128; b < 128; b++)
                  beat(1, a, b, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
            idle(1);
         end
      join
      cycles(4);
      cap_ans.delete();
      cap_cy.delete();

      // random traffic with stalls, accumulate and clears
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            w = wd(i);
            in_valid[i]  = ($urandom_range(0, 3) != 0);
            out_ready[i] = ($urandom_range(0, 3) != 0);
            a_drv[i] = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
            b_drv[i] = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
            sub[i] = 1'($urandom_range(0, 1));
            acc[i] = 1'($urandom_range(0, 1));
            sat[i] = 1'($urandom_range(0, 1));
            clr[i] = ($urandom_range(0, 15) == 0);
         end
         cycles(1);
      end
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b0;
         out_ready[i] = 1'b1;
         clr[i] = 1'b0;
      end
      cycles(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
